// File: rtl/pipe_stage_ctl.sv
// Generic pipeline-register chain with per-boundary stall, bubble insertion, flush and valid bit.
// Optional PIPE_STAGE_STATS_EN adds saturating bubble and flush event counters.
module pipe_stage_ctl #(
  parameter int unsigned       DATA_W  = 72,
  parameter int unsigned       DEPTH   = 1,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DEPTH:0]    i_stall,
  input  logic              i_flush,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  output logic [2:0]        o_occ
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]       o_bubble_cnt,
  output logic [15:0]       o_flush_cnt
`endif
);

  logic [DATA_W-1:0] r_data      [1:DEPTH];
  logic [DEPTH:1]    r_valid;
  logic [DATA_W-1:0] w_data_d    [1:DEPTH];
  logic [DEPTH:1]    w_valid_d;
  logic [DATA_W-1:0] w_src_data  [1:DEPTH];
  logic [DEPTH:1]    w_src_valid;
  logic [DEPTH:1]    w_bubble;
  logic [2:0]        r_occ;
  logic [2:0]        w_occ_d;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_src
    if (k == 1) begin : g_head
      assign w_src_data[k]  = i_in_data;
      assign w_src_valid[k] = i_in_valid;
    end else begin : g_chain
      assign w_src_data[k]  = r_data[k-1];
      assign w_src_valid[k] = r_valid[k-1];
    end
    // Upstream frozen while downstream drains: register k must present a NOP.
    assign w_bubble[k] = i_stall[k-1] & ~i_stall[k];
  end

  always_comb begin
    for (int k = 1; k <= DEPTH; k++) begin
      w_data_d[k]  = r_data[k];
      w_valid_d[k] = r_valid[k];
      if (i_flush || w_bubble[k]) begin
        w_data_d[k]  = NOP_VAL;
        w_valid_d[k] = 1'b0;
      end else if (!i_stall[k-1]) begin
        w_data_d[k]  = w_src_data[k];
        w_valid_d[k] = w_src_valid[k];
      end
    end
  end

  always_comb begin
    w_occ_d = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      w_occ_d = w_occ_d + {2'b00, w_valid_d[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        r_data[k] <= NOP_VAL;
      end
      r_valid <= '0;
      r_occ   <= '0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        r_data[k] <= w_data_d[k];
      end
      r_valid <= w_valid_d;
      r_occ   <= w_occ_d;
    end
  end

  assign o_out_valid = r_valid[DEPTH];
  assign o_out_data  = r_data[DEPTH];
  assign o_occ       = r_occ;

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] w_bubble_cnt_d;
  logic [15:0] r_flush_cnt;
  logic [15:0] w_flush_cnt_d;

  // Counters saturate rather than wrap so a long run never reads as a small count.
  always_comb begin
    w_bubble_cnt_d = r_bubble_cnt;
    w_flush_cnt_d  = r_flush_cnt;
    if (!i_flush && w_bubble[DEPTH] && (r_bubble_cnt != '1)) begin
      w_bubble_cnt_d = r_bubble_cnt + 32'd1;
    end
    if (i_flush && (r_flush_cnt != '1)) begin
      w_flush_cnt_d = r_flush_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_bubble_cnt <= w_bubble_cnt_d;
      r_flush_cnt  <= w_flush_cnt_d;
    end
  end

  assign o_bubble_cnt = r_bubble_cnt;
  assign o_flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_ctl.sv
// Bench for pipe_stage_ctl: DEPTH 1/2/3 instances checked against a scoreboard of
// expected outputs plus directed checks; stats checks run when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_ctl;

  localparam logic [7:0] NOP = 8'hA5;

  typedef struct {
    int         inst;
    logic       v;
    logic [7:0] d;
    logic [2:0] occ;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] st1;
  logic [2:0] st2;
  logic [3:0] st3;

  logic       ov1, ov2, ov3;
  logic [7:0] od1, od2, od3;
  logic [2:0] oc1, oc2, oc3;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] bc1, bc2, bc3;
  logic [15:0] fc1, fc2, fc3;
`endif

  int n_checks = 0;
  int n_errors = 0;

  exp_t       sb_q[$];
  logic       m_v [3][0:4];
  logic [7:0] m_d [3][0:4];

  always #5 clk = ~clk;

  pipe_stage_ctl #(.DATA_W(8), .DEPTH(1), .NOP_VAL(NOP)) u_dut1 (
    .clk(clk), .rst(rst), .i_stall(st1), .i_flush(flush), .i_in_valid(in_valid),
    .i_in_data(in_data), .o_out_valid(ov1), .o_out_data(od1), .o_occ(oc1)
`ifdef PIPE_STAGE_STATS_EN
    , .o_bubble_cnt(bc1), .o_flush_cnt(fc1)
`endif
  );

  pipe_stage_ctl #(.DATA_W(8), .DEPTH(2), .NOP_VAL(NOP)) u_dut2 (
    .clk(clk), .rst(rst), .i_stall(st2), .i_flush(flush), .i_in_valid(in_valid),
    .i_in_data(in_data), .o_out_valid(ov2), .o_out_data(od2), .o_occ(oc2)
`ifdef PIPE_STAGE_STATS_EN
    , .o_bubble_cnt(bc2), .o_flush_cnt(fc2)
`endif
  );

  pipe_stage_ctl #(.DATA_W(8), .DEPTH(3), .NOP_VAL(NOP)) u_dut3 (
    .clk(clk), .rst(rst), .i_stall(st3), .i_flush(flush), .i_in_valid(in_valid),
    .i_in_data(in_data), .o_out_valid(ov3), .o_out_data(od3), .o_occ(oc3)
`ifdef PIPE_STAGE_STATS_EN
    , .o_bubble_cnt(bc3), .o_flush_cnt(fc3)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference behaviour for one instance, applied to the current bench inputs.
  task automatic model_step(input int i, input logic [4:0] st, output exp_t e);
    int         dep = i + 1;
    logic       nv [0:4];
    logic [7:0] nd [0:4];
    logic       sv;
    logic [7:0] sd;
    int         cnt = 0;
    for (int k = 1; k <= dep; k++) begin
      if (k == 1) begin
        sv = in_valid;
        sd = in_data;
      end else begin
        sv = m_v[i][k-1];
        sd = m_d[i][k-1];
      end
      nv[k] = m_v[i][k];
      nd[k] = m_d[i][k];
      if (rst || flush || (st[k-1] && !st[k])) begin
        nv[k] = 1'b0;
        nd[k] = NOP;
      end else if (!st[k-1]) begin
        nv[k] = sv;
        nd[k] = sd;
      end
    end
    for (int k = 1; k <= dep; k++) begin
      m_v[i][k] = nv[k];
      m_d[i][k] = nd[k];
      if (nv[k]) cnt++;
    end
    e.inst = i;
    e.v    = nv[dep];
    e.d    = nd[dep];
    e.occ  = 3'(cnt);
  endtask

  task automatic tick(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] s3);
    exp_t e;
    st1 = s1[1:0];
    st2 = s2[2:0];
    st3 = s3[3:0];
    model_step(0, {3'b000, s1[1:0]}, e);
    sb_q.push_back(e);
    model_step(1, {2'b00, s2[2:0]}, e);
    sb_q.push_back(e);
    model_step(2, {1'b0, s3[3:0]}, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) begin
      logic       av;
      logic [7:0] ad;
      logic [2:0] ao;
      e = sb_q.pop_front();
      case (e.inst)
        0:       begin av = ov1; ad = od1; ao = oc1; end
        1:       begin av = ov2; ad = od2; ao = oc2; end
        default: begin av = ov3; ad = od3; ao = oc3; end
      endcase
      check_eq($sformatf("sb_d%0d_valid", e.inst + 1), {31'd0, av}, {31'd0, e.v});
      check_eq($sformatf("sb_d%0d_data", e.inst + 1), {24'd0, ad}, {24'd0, e.d});
      check_eq($sformatf("sb_d%0d_occ", e.inst + 1), {29'd0, ao}, {29'd0, e.occ});
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k <= 4; k++) begin
        m_v[i][k] = 1'b0;
        m_d[i][k] = NOP;
      end
    end
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b1, 8'hAB);
    st1 = '0; st2 = '0; st3 = '0;

    // Reset holds despite valid producer data.
    tick(5'd0, 5'd0, 5'd0);
    tick(5'd0, 5'd0, 5'd0);
    check_eq("rst_valid1", {31'd0, ov1}, 32'd0);
    check_eq("rst_data1", {24'd0, od1}, {24'd0, NOP});
    check_eq("rst_occ3", {29'd0, oc3}, 32'd0);
    check_eq("rst_data3", {24'd0, od3}, {24'd0, NOP});
    rst = 1'b0;

    // Streaming through DEPTH=2.
    drive(1'b1, 8'h01); tick(5'd0, 5'd0, 5'd0);
    check_eq("stream_lat1_valid", {31'd0, ov2}, 32'd0);
    drive(1'b1, 8'h02); tick(5'd0, 5'd0, 5'd0);
    check_eq("stream_out1", {24'd0, od2}, 32'h01);
    check_eq("stream_occ", {29'd0, oc2}, 32'd2);
    drive(1'b1, 8'h03); tick(5'd0, 5'd0, 5'd0);
    check_eq("stream_out2", {24'd0, od2}, 32'h02);
    drive(1'b0, 8'h00); tick(5'd0, 5'd0, 5'd0);
    check_eq("stream_out3", {24'd0, od2}, 32'h03);
    check_eq("stream_out3_valid", {31'd0, ov2}, 32'd1);

    // Bubble on DEPTH=1.
    drive(1'b1, 8'h55); tick(5'b00001, 5'd0, 5'd0);
    check_eq("bubble_valid", {31'd0, ov1}, 32'd0);
    check_eq("bubble_data", {24'd0, od1}, {24'd0, NOP});
    tick(5'd0, 5'd0, 5'd0);
    check_eq("bubble_reload", {24'd0, od1}, 32'h55);

    // Hold on DEPTH=1 while producer data changes.
    drive(1'b1, 8'h77); tick(5'd0, 5'd0, 5'd0);
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 8'(8'h10 * (n + 1)));
      tick(5'b00011, 5'd0, 5'd0);
      check_eq("hold_data", {24'd0, od1}, 32'h77);
      check_eq("hold_valid", {31'd0, ov1}, 32'd1);
    end

    // Flush beats stall on DEPTH=3.
    drive(1'b1, 8'h31); tick(5'd0, 5'd0, 5'd0);
    drive(1'b1, 8'h32); tick(5'd0, 5'd0, 5'd0);
    drive(1'b1, 8'h33); tick(5'd0, 5'd0, 5'd0);
    check_eq("fill_occ3", {29'd0, oc3}, 32'd3);
    check_eq("fill_out3", {24'd0, od3}, 32'h31);
    flush = 1'b1;
    tick(5'd0, 5'd0, 5'b00011);
    flush = 1'b0;
    check_eq("flush_occ3", {29'd0, oc3}, 32'd0);
    check_eq("flush_valid3", {31'd0, ov3}, 32'd0);
    check_eq("flush_data3", {24'd0, od3}, {24'd0, NOP});

    // Random traffic, including non-monotonic stall vectors and mid-stall resets.
    for (int n = 0; n < 300; n++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 15) == 0);
      drive(1'($urandom), 8'($urandom));
      tick(5'($urandom), 5'($urandom), 5'($urandom));
    end
    rst = 1'b0;
    flush = 1'b0;

`ifdef PIPE_STAGE_STATS_EN
    rst = 1'b1;
    tick(5'd0, 5'd0, 5'd0);
    rst = 1'b0;
    check_eq("stats_rst_bubble", bc1, 32'd0);
    flush = 1'b1;
    tick(5'd0, 5'd0, 5'd0);
    tick(5'd0, 5'd0, 5'd0);
    flush = 1'b0;
    check_eq("stats_flush_cnt", {16'd0, fc1}, 32'd2);
    force u_dut1.r_bubble_cnt = 32'hFFFF_FFFE;
    #1;
    release u_dut1.r_bubble_cnt;
    for (int n = 0; n < 3; n++) begin
      tick(5'b00001, 5'd0, 5'd0);
    end
    check_eq("stats_bubble_sat", bc1, 32'hFFFF_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_ctl.md
Name: pipe_stage_ctl

Overview:
Parametrised pipeline-register chain carrying one packed stage payload (alusel/aluop/operands/wd/wreg or any other bundle) between pipeline stages. It replaces fixed per-boundary registers with a generic block that adds per-boundary stall handling, bubble (NOP) insertion, flush and a valid bit. DEPTH back-to-back boundaries are supported, so one instance can also retime a multi-cycle datapath segment. It sits between decode and execute by default (DEPTH=1) and is reused at other boundaries.

Parameters:
DATA_W, 72, payload width in bits (1..256).
DEPTH, 1, number of register boundaries in the chain (1..4).
NOP_VAL, {DATA_W{1'b0}}, payload loaded on reset, flush or bubble insertion.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  reset rst, synchronous, active-high.
stall  input  DEPTH+1  stall[k]=1: stage k is stalled; stage 0 is the producer, stage DEPTH the final consumer.
flush  input  1  discard all in-flight entries.
in_valid  input  1  producer payload is a real instruction.
in_data  input  DATA_W  producer payload.
out_valid  output  1  valid bit of register DEPTH.
out_data  output  DATA_W  payload of register DEPTH.
occ  output  3  number of registers currently holding valid=1 (0..DEPTH).

Behaviour:
- Register k (k=1..DEPTH) sits between stage k-1 and stage k; it holds {valid_k, data_k}. Source of register 1 is {in_valid,in_data}; source of register k>1 is register k-1.
- Reset (rst=1 at posedge): every data_k=NOP_VAL, valid_k=0, occ=0. Also applies mid-stall and mid-flush; rst has top priority.
- Per-register update, priority order, evaluated independently for each k at each posedge:
  1. flush=1 -> data_k=NOP_VAL, valid_k=0 (all registers, same edge).
  2. stall[k-1]=1 and stall[k]=0 -> bubble: data_k=NOP_VAL, valid_k=0.
  3. stall[k-1]=0 -> load source (data and valid).
  4. otherwise (both stalled) -> hold.
- Latency: DEPTH cycles from in_data to out_data with stall all-zero; throughput one entry per cycle.
- stall vector is not required to be monotonic; the rules above apply literally per register. An entry whose upstream loads while downstream holds is overwritten (no back-pressure storage); the stall controller guarantees a contiguous stalled prefix, and the block performs no check.
- occ: registered population count of valid_1..valid_DEPTH after the update; width fixed at 3 bits; upper bits 0 for small DEPTH.
- out_valid/out_data are direct register outputs; no combinational path from any input to any output.
- invalid entries keep propagating their data field unchanged (not forced to NOP) except under rules 1/2.

Optional Feature:
Macro PIPE_STAGE_STATS_EN. When defined: adds outputs bubble_cnt (32-bit) and flush_cnt (16-bit), both reset to 0 on rst. bubble_cnt increments by 1 each cycle register DEPTH takes rule 2; flush_cnt increments on each cycle flush=1. Both saturate at all-ones (no wrap). When undefined: ports absent, no counter logic, behaviour otherwise identical.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=0xAB -> out_valid=0, out_data=NOP_VAL, occ=0; release rst.
- Streaming DEPTH=2, stall=0: inject 0x01,0x02,0x03 with valid=1 on consecutive cycles -> out_data 0x01 appears on the 2nd edge after injection, then 0x02, 0x03; occ=2 at steady state.
- Bubble DEPTH=1: stall=2'b01 for one cycle while in_data=0x55 -> out_valid=0, out_data=NOP_VAL next edge; stall=0 following -> 0x55 loaded.
- Hold DEPTH=1: register holds 0x77, stall=2'b11 for 3 cycles with in_data changing -> out_data stays 0x77, out_valid=1 throughout.
- Flush vs stall DEPTH=3, all registers valid: flush=1 with stall=4'b0011 -> next edge all valid=0, occ=0, out_data=NOP_VAL.
- Stats (PIPE_STAGE_STATS_EN): force 0xFFFFFFFE into bubble_cnt, apply 3 bubble cycles -> bubble_cnt=0xFFFFFFFF, no wrap; 2 flush cycles -> flush_cnt=2.
